// File: rtl/channel_rr_arbiter_32.sv
// channel_rr_arbiter_32: 32-requester round-robin channel arbiter with hold-until-Done ownership
// Ports: clk, rst (sync, active-high); Req[31:0] requests; Done releases the owner;
//        Enable gates new grants; Grant[31:0] one-hot, Grant_ID[4:0], Grant_Valid, Timeout pulse.
// Optional: define ARB_TIMEOUT_EN to force release after TIMEOUT_CYCLES busy cycles without Done.
module channel_rr_arbiter_32 #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Req,
    input  logic        Done,
    input  logic        Enable,
    output logic [31:0] Grant,
    output logic [4:0]  Grant_ID,
    output logic        Grant_Valid,
    output logic        Timeout
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nx;
    logic [4:0] last, win;
    logic [31:0] cand, masked;
    logic release_now, forced, grant_new;

    function automatic logic [4:0] hi_idx(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++)
            if (v[i]) idx = 5'(i);
        return idx;
    endfunction

    // The current owner never competes on its own release, so it only wins again after an idle cycle.
    always_comb begin
        release_now = (state == BUSY) && (Done || forced);
        cand = (state == BUSY) ? Req & ~Grant : Req;
        masked = cand & ((32'd1 << last) - 32'd1);
        win = (|masked) ? hi_idx(masked) : hi_idx(cand);
        grant_new = Enable && (|cand) && (state == IDLE || release_now);
        state_nx = grant_new ? BUSY : (state == BUSY && !release_now) ? BUSY : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            Grant <= '0;
            Grant_ID <= '0;
            last <= '0;
        end else begin
            state <= state_nx;
            if (grant_new) begin
                Grant <= 32'd1 << win;
                Grant_ID <= win;
                last <= win;
            end else if (state_nx == IDLE) begin
                Grant <= '0;
                Grant_ID <= '0;
            end
        end
    end

    assign Grant_Valid = (state == BUSY);

`ifdef ARB_TIMEOUT_EN
    logic [15:0] cnt;
    assign forced = (state == BUSY) && !Done && cnt == 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            Timeout <= 1'b0;
        end else begin
            cnt <= grant_new ? 16'd0 : (state == BUSY && !Done) ? cnt + 16'd1 : cnt;
            Timeout <= forced;
        end
    end
`else
    assign forced = 1'b0;
    assign Timeout = 1'b0;
`endif
endmodule

// File: tb/tb_channel_rr_arbiter_32.sv
// tb_channel_rr_arbiter_32: directed table, corner sequences and random run against a search-based model
module tb_channel_rr_arbiter_32;
    localparam int T = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic clk = 1'b0, rst, done, enable, grant_valid, timeout;
    logic [31:0] req, grant;
    logic [4:0] grant_id;
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    channel_rr_arbiter_32 #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .Req(req), .Done(done), .Enable(enable),
        .Grant(grant), .Grant_ID(grant_id), .Grant_Valid(grant_valid), .Timeout(timeout)
    );

    typedef struct {
        logic r;
        logic [31:0] q;
        logic d;
        logic e;
        logic v;
        logic [4:0] id;
    } vec_t;
    vec_t tbl[29];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input logic r, input logic [31:0] q, input logic d, input logic e);
        rst = r; req = q; done = d; enable = e;
        @(posedge clk);
        #1;
    endtask

    // Round-robin winner: first set bit searching downward from just below lst, else from the top.
    function automatic int pick(input logic [31:0] v, input int lst);
        for (int i = lst - 1; i >= 0; i--) if (v[i]) return i;
        for (int i = 31; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    int owner, last, tcnt, bad;
    logic exp_to, forced;
    logic [31:0] v, q;
    logic r, d, e;

    initial begin
        rst = 1'b1; req = '0; done = 1'b0; enable = 1'b0;
        tbl[0]  = '{1, 32'h0, 0, 0, 0, 0};
        tbl[1]  = '{0, 32'h5, 0, 1, 1, 2};
        tbl[2]  = '{0, 32'h5, 0, 1, 1, 2};
        tbl[3]  = '{0, 32'h5, 1, 1, 1, 0};
        tbl[4]  = '{0, 32'h0, 1, 1, 0, 0};
        tbl[5]  = '{1, 32'h0, 0, 1, 0, 0};
        tbl[6]  = '{0, 32'h8000_0001, 0, 1, 1, 31};
        tbl[7]  = '{0, 32'h8000_0001, 1, 1, 1, 0};
        tbl[8]  = '{0, 32'h8000_0001, 1, 1, 1, 31};
        tbl[9]  = '{0, 32'h8000_0001, 1, 1, 1, 0};
        tbl[10] = '{0, 32'h4, 1, 1, 1, 2};
        tbl[11] = '{0, 32'h0, 0, 1, 1, 2};
        tbl[12] = '{0, 32'h0, 0, 1, 1, 2};
        tbl[13] = '{0, 32'h0, 0, 1, 1, 2};
        tbl[14] = '{0, 32'h0, 1, 1, 0, 0};
        tbl[15] = '{0, 32'h0, 1, 1, 0, 0};
        tbl[16] = '{1, 32'hFFFF_FFFF, 0, 0, 0, 0};
        tbl[17] = '{0, 32'hFFFF_FFFF, 0, 0, 0, 0};
        tbl[18] = '{0, 32'hFFFF_FFFF, 0, 1, 1, 31};
        tbl[19] = '{1, 32'h0, 0, 1, 0, 0};
        tbl[20] = '{0, 32'h80, 0, 1, 1, 7};
        tbl[21] = '{1, 32'h80, 0, 1, 0, 0};
        tbl[22] = '{0, 32'h80, 0, 1, 1, 7};
        tbl[23] = '{0, 32'h81, 1, 1, 1, 0};
        tbl[24] = '{0, 32'h81, 1, 1, 1, 7};
        tbl[25] = '{0, 32'h80, 1, 1, 0, 0};
        tbl[26] = '{0, 32'h80, 0, 1, 1, 7};
        tbl[27] = '{0, 32'h1, 1, 0, 0, 0};
        tbl[28] = '{0, 32'h1, 0, 0, 0, 0};
        for (int i = 0; i < 29; i++) begin
            step(tbl[i].r, tbl[i].q, tbl[i].d, tbl[i].e);
            chk($sformatf("tbl%0d_valid", i), 32'(grant_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_id", i), 32'(grant_id), 32'(tbl[i].id));
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].v ? 32'd1 << tbl[i].id : 32'd0);
        end

        step(1, 32'h0, 0, 1);
        step(0, 32'h3, 0, 1);
        chk("hold_first_id", 32'(grant_id), 32'd1);
        if (TO_EN) begin
            for (int i = 0; i < T - 1; i++) begin
                step(0, 32'h3, 0, 1);
                chk($sformatf("to_hold%0d", i), {grant_id, timeout}, {5'd1, 1'b0});
            end
            step(0, 32'h3, 0, 1);
            chk("to_release", {grant_id, grant_valid, timeout}, {5'd0, 1'b1, 1'b1});
            step(0, 32'h3, 0, 1);
            chk("to_pulse_end", 32'(timeout), 32'd0);
        end else begin
            bad = 0;
            for (int i = 0; i < 1000; i++) begin
                step(0, 32'h3, 0, 1);
                if (grant_id !== 5'd1 || timeout !== 1'b0 || grant_valid !== 1'b1) bad++;
            end
            chk("hold_1000_bad_cycles", 32'(bad), 32'd0);
            chk("hold_1000_id", 32'(grant_id), 32'd1);
        end

        owner = -1; last = 0; tcnt = 0; exp_to = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            r = (n == 0) || ($urandom_range(63) == 0);
            q = ($urandom_range(3) == 0) ? ($urandom & 32'h0000_00FF) : ($urandom & $urandom);
            d = ($urandom_range(2) == 0);
            e = ($urandom_range(7) != 0);
            if (r) begin
                owner = -1; last = 0; tcnt = 0; exp_to = 1'b0;
            end else begin
                forced = TO_EN && owner >= 0 && !d && tcnt == T - 1;
                exp_to = forced;
                if (owner < 0 || d || forced) begin
                    v = q;
                    if (owner >= 0) v[owner] = 1'b0;
                    if (e && v != 0) begin
                        owner = pick(v, last);
                        last = owner;
                        tcnt = 0;
                    end else owner = -1;
                end else tcnt++;
            end
            step(r, q, d, e);
            chk($sformatf("rnd%0d_grant", n), grant, owner < 0 ? 32'd0 : 32'd1 << owner);
            chk($sformatf("rnd%0d_id", n), 32'(grant_id), owner < 0 ? 32'd0 : 32'(owner));
            chk($sformatf("rnd%0d_valid", n), 32'(grant_valid), 32'(owner >= 0));
            chk($sformatf("rnd%0d_timeout", n), 32'(timeout), 32'(exp_to));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/channel_rr_arbiter_32.md
CHANNEL_RR_ARBITER_32 -- requirements
Module: channel_rr_arbiter_32

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, maximum cycles a grant is held before forced release (used only under the Configuration macro); legal range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 Req  input  32  request vector; bit i = requester i wants the channel.
REQ-005 Done  input  1  current owner releases the channel this cycle.
REQ-006 Enable  input  1  when low, no new grant is issued; an existing grant is unaffected.
REQ-007 Grant  output  32  registered one-hot grant; all-zero when no owner.
REQ-008 Grant_ID  output  5  registered binary index of the owner; 0 when no owner.
REQ-009 Grant_Valid  output  1  registered; high while a grant is held.
REQ-010 Timeout  output  1  registered one-cycle pulse on forced release (constant 0 when the macro is absent).

Function
REQ-011 Two states: IDLE (no owner) and BUSY (owner held); Grant_Valid SHALL equal (state==BUSY).
REQ-012 Register Last[4:0] SHALL hold the index of the most recent grant.
REQ-013 Selection SHALL be combinational: M = Req AND mask of bits strictly below Last; if M nonzero, winner = highest set index of M, else winner = highest set index of Req (MSB-first priority encode, wrap-around).
REQ-014 IDLE: if Enable=1 and Req nonzero, next edge SHALL enter BUSY with Grant=one-hot(winner), Grant_ID=winner, Last=winner; latency Req->Grant = 1 cycle.
REQ-015 IDLE with Req=0 or Enable=0 SHALL remain IDLE with all grant outputs zero.
REQ-016 BUSY: Grant, Grant_ID, Last SHALL hold until Done=1, even if the owner's Req bit drops.
REQ-017 BUSY with Done=1: selection SHALL use Req masked with the owner's bit cleared; if Enable=1 and that vector is nonzero, next edge SHALL grant the winner directly (back-to-back, no idle cycle); otherwise next edge SHALL return to IDLE.
REQ-018 Done while IDLE SHALL be ignored.
REQ-019 Owner re-requesting after Done SHALL be granted again only when no other requester is pending.
REQ-020 Grant SHALL never have more than one bit set; Grant_ID SHALL always equal the encoded index of Grant.

Reset
REQ-021 rst=1 at an edge SHALL force IDLE, Grant=0, Grant_ID=0, Grant_Valid=0, Timeout=0, Last=0, timeout counter=0, overriding all other inputs, including mid-grant.
REQ-022 With Last=0 after reset, the first grant SHALL go to the highest-index requester.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN: when defined, a 16-bit counter SHALL clear on every new grant and increment each BUSY cycle without Done; when it reaches TIMEOUT_CYCLES-1 without Done, the arbiter SHALL treat the cycle as Done (REQ-017) and pulse Timeout for one cycle.
REQ-024 Without ARB_TIMEOUT_EN, no counter is present, Timeout SHALL be tied 0, and a grant SHALL be held indefinitely until Done.

Verification
REQ-025 Reset then Req=0x0000_0005, Enable=1 -> cycle+1 Grant=0x0000_0004, Grant_ID=2, Grant_Valid=1.
REQ-026 Req=0x8000_0001 held, Done pulsed on every BUSY cycle -> grants alternate 31,0,31,0 with no IDLE cycles.
REQ-027 Owner 2 drops Req while BUSY, Done=0 for 10 cycles -> Grant_ID stays 2; Done=1 with Req=0 -> IDLE next cycle, Grant=0.
REQ-028 Enable=0, Req=0xFFFF_FFFF -> Grant_Valid stays 0; Enable=1 -> Grant_ID=31 next cycle.
REQ-029 rst=1 during BUSY with Grant_ID=7 -> next cycle all outputs 0, state IDLE; Req=0x80 afterwards -> Grant_ID=7.
REQ-030 ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, Req=0x3, Done=0 -> Grant_ID=1 for 4 cycles, Timeout pulse, then Grant_ID=0; without the macro Grant_ID=1 persists for 1000 cycles.
